// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: per-stage writer tags drive forwarding selects, load-use stall and flushes.
// Optional HAZARD_STATS_EN macro adds saturating stall/forward event counters.
module pipe_hazard_unit #(
  parameter int unsigned AW     = 4,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned PC_IDX = 15,
  localparam int unsigned W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dec_valid,
  input  logic                 dec_we,
  input  logic                 dec_load,
  input  logic [AW-1:0]        dec_wa,
  input  logic [NSRC*AW-1:0]   dec_ra,
  input  logic [NSRC*AW-1:0]   ex_ra,
  input  logic                 branch_taken_e,
  output logic [NSRC*W-1:0]    fwd_sel,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          fwd_cnt
);

  localparam logic [AW-1:0] PcIdx = AW'(PC_IDX);

  logic [DEPTH-1:0] valid_q, valid_d, we_q, we_d, load_q, load_d;
  logic [AW-1:0]    wa_q [DEPTH];
  logic [AW-1:0]    wa_d [DEPTH];
  logic [DEPTH-1:0] match;
  logic             lwstall;

  always_comb begin
    for (int s = 0; s < int'(DEPTH); s++) begin
      match[s] = valid_q[s] & we_q[s] & (wa_q[s] != PcIdx);
    end
  end

  // Scan oldest to youngest so the youngest matching stage overwrites the select.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      for (int s = int'(DEPTH) - 1; s >= 1; s--) begin
        if (match[s] && (wa_q[s] == ex_ra[i*AW +: AW])) begin
          fwd_sel[i*W +: W] = W'(s);
        end
      end
    end
  end

  always_comb begin
    lwstall = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (match[0] && load_q[0] && (wa_q[0] == dec_ra[i*AW +: AW])) begin
        lwstall = 1'b1;
      end
    end
  end

  assign stall_f = lwstall;
  assign stall_d = lwstall;
  assign flush_d = branch_taken_e;
  assign flush_e = lwstall | branch_taken_e;

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    load_d  = load_q;
    wa_d    = wa_q;
    if (en) begin
      for (int s = 1; s < int'(DEPTH); s++) begin
        valid_d[s] = valid_q[s-1];
        we_d[s]    = we_q[s-1];
        load_d[s]  = load_q[s-1];
        wa_d[s]    = wa_q[s-1];
      end
      valid_d[0] = dec_valid & ~flush_e;
      we_d[0]    = dec_we;
      load_d[0]  = dec_load;
      wa_d[0]    = dec_wa;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      we_q    <= '0;
      load_q  <= '0;
      for (int s = 0; s < int'(DEPTH); s++) begin
        wa_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      load_q  <= load_d;
      wa_q    <= wa_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (en) begin
      if (lwstall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if ((|fwd_sel) && (fwd_cnt_q != 16'hFFFF)) fwd_cnt_d = fwd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed hazard scenarios plus random traffic against a stage-list model.
module tb_pipe_hazard_unit;
  localparam int AW = 4, DEPTH = 3, NSRC = 2, PC = 15;
  localparam int W = $clog2(DEPTH);
`ifdef HAZARD_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, en = 1'b1;
  logic dec_valid = 1'b0, dec_we = 1'b0, dec_load = 1'b0, branch_taken_e = 1'b0;
  logic [AW-1:0]      dec_wa = '0;
  logic [NSRC*AW-1:0] dec_ra = '0, ex_ra = '0;
  logic [NSRC*W-1:0]  fwd_sel;
  logic stall_f, stall_d, flush_d, flush_e;
  logic [15:0] stall_cnt, fwd_cnt;

  pipe_hazard_unit dut (
    .clk(clk), .reset(reset), .en(en), .dec_valid(dec_valid), .dec_we(dec_we),
    .dec_load(dec_load), .dec_wa(dec_wa), .dec_ra(dec_ra), .ex_ra(ex_ra),
    .branch_taken_e(branch_taken_e), .fwd_sel(fwd_sel), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e), .stall_cnt(stall_cnt),
    .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; bit we; bit ld; int wa;} tag_t;
  tag_t stg[DEPTH];
  int unsigned m_stall = 0, m_fwd = 0;
  bit cv, cwe, cld, cbr, cen = 1'b1;
  int cwa;
  int cd[NSRC];
  int ce[NSRC];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit hit(int s, int r);
    return stg[s].v && stg[s].we && stg[s].wa != PC && stg[s].wa == r;
  endfunction

  function automatic int exp_fwd(int r);
    for (int s = 1; s < DEPTH; s++) if (hit(s, r)) return s;
    return 0;
  endfunction

  function automatic bit exp_lw();
    for (int i = 0; i < NSRC; i++) if (stg[0].ld && hit(0, cd[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < DEPTH; s++) stg[s] = '{0, 0, 0, 0};
    m_stall = 0;
    m_fwd = 0;
  endtask

  task automatic eval_chk();
    logic [31:0] fv;
    bit lw;
    fv = '0;
    for (int i = 0; i < NSRC; i++) fv = fv | (32'(exp_fwd(ce[i])) << (i * W));
    lw = exp_lw();
    chk("fwd_sel", 32'(fwd_sel), fv);
    chk("stall_f", 32'(stall_f), 32'(lw));
    chk("stall_d", 32'(stall_d), 32'(lw));
    chk("flush_d", 32'(flush_d), 32'(cbr));
    chk("flush_e", 32'(flush_e), 32'(lw | cbr));
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    chk("fwd_cnt", 32'(fwd_cnt), m_fwd);
  endtask

  task automatic drive_chk(input bit v, input bit we, input bit ld, input int wa,
                           input int d0, input int d1, input int e0, input int e1,
                           input bit br, input bit e);
    @(negedge clk);
    cv = v; cwe = we; cld = ld; cwa = wa; cbr = br; cen = e;
    cd[0] = d0; cd[1] = d1; ce[0] = e0; ce[1] = e1;
    dec_valid = v; dec_we = we; dec_load = ld; dec_wa = AW'(wa);
    branch_taken_e = br; en = e;
    for (int i = 0; i < NSRC; i++) begin
      dec_ra[i*AW +: AW] = AW'(cd[i]);
      ex_ra[i*AW +: AW]  = AW'(ce[i]);
    end
    #1;
    eval_chk();
  endtask

  task automatic adv();
    bit lw, anyf;
    lw = exp_lw();
    anyf = 1'b0;
    for (int i = 0; i < NSRC; i++) if (exp_fwd(ce[i]) != 0) anyf = 1'b1;
    @(posedge clk);
    if (cen) begin
      if (Stats && lw && m_stall < 65535) m_stall++;
      if (Stats && anyf && m_fwd < 65535) m_fwd++;
      for (int s = DEPTH - 1; s >= 1; s--) stg[s] = stg[s-1];
      stg[0] = '{cv && !(lw || cbr), cwe, cld, cwa};
    end
  endtask

  task automatic push(input bit v, input bit we, input bit ld, input int wa);
    drive_chk(v, we, ld, wa, 0, 0, 0, 0, 1'b0, 1'b1);
    adv();
  endtask

  function automatic int rreg();
    int r;
    r = int'($urandom_range(0, 6));
    return (r == 6) ? PC : r;
  endfunction

  initial begin
    model_reset();
    cd = '{0, 0};
    ce = '{3, 3};
    ex_ra = {4'd3, 4'd3};
    #1 reset = 1'b0;
    cbr = 1'b1; branch_taken_e = 1'b1;
    #2 eval_chk();
    cbr = 1'b0; branch_taken_e = 1'b0;
    #1 eval_chk();
    @(negedge clk) reset = 1'b1;

    // Forward from Memory
    push(1, 1, 0, 3);
    push(1, 0, 0, 0);
    drive_chk(1, 0, 0, 0, 0, 0, 3, 0, 0, 1);
    chk("fwd_mem", 32'(fwd_sel[0 +: W]), 1);
    adv();
    // Forward from Writeback
    push(1, 1, 0, 3);
    push(1, 0, 0, 0);
    push(1, 0, 0, 0);
    drive_chk(1, 0, 0, 0, 0, 0, 3, 0, 0, 1);
    chk("fwd_wb", 32'(fwd_sel[0 +: W]), 2);
    adv();
    // Youngest wins
    push(1, 1, 0, 5);
    push(1, 1, 0, 5);
    push(1, 0, 0, 0);
    drive_chk(1, 0, 0, 0, 0, 0, 0, 5, 0, 1);
    chk("fwd_young", 32'(fwd_sel[W +: W]), 1);
    adv();
    // Load-use, then the load reaches Memory with a bubble behind it
    push(1, 1, 1, 2);
    drive_chk(1, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    chk("lu_stall", 32'({stall_f, stall_d, flush_e}), 32'b111);
    adv();
    drive_chk(1, 0, 0, 0, 2, 0, 2, 0, 0, 1);
    chk("lu_release", 32'(stall_f), 0);
    chk("lu_load_fwd", 32'(fwd_sel[0 +: W]), 1);
    adv();
    // PC index never matches
    push(1, 1, 0, 15);
    push(1, 0, 0, 0);
    drive_chk(1, 0, 0, 0, 0, 0, 15, 15, 0, 1);
    chk("pc_fwd", 32'(fwd_sel), 0);
    adv();
    push(1, 1, 1, 15);
    drive_chk(1, 0, 0, 0, 15, 15, 0, 0, 0, 1);
    chk("pc_lw", 32'(stall_f), 0);
    adv();
    // Branch together with load-use
    push(1, 1, 1, 2);
    drive_chk(1, 0, 0, 0, 2, 0, 0, 0, 1, 1);
    chk("br_lu", 32'({stall_f, stall_d, flush_d, flush_e}), 32'b1111);
    adv();
    // Reset mid-stall
    push(1, 1, 1, 2);
    drive_chk(1, 0, 0, 0, 2, 0, 0, 0, 0, 1);
    chk("pre_rst_stall", 32'(stall_f), 1);
    #1 reset = 1'b0;
    model_reset();
    #1 eval_chk();
    chk("rst_abort", 32'(stall_f), 0);
    @(negedge clk) reset = 1'b1;
    // Enable low holds the tags
    push(1, 1, 0, 5);
    push(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive_chk(1, 1, 0, 7, 0, 0, 5, 0, 0, 0);
      chk("en_hold", 32'(fwd_sel[0 +: W]), 1);
      adv();
    end
    drive_chk(1, 1, 0, 7, 0, 0, 5, 0, 0, 1);
    chk("en_resume", 32'(fwd_sel[0 +: W]), 1);
    adv();

    for (int n = 0; n < 500; n++) begin
      drive_chk(1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                rreg(), rreg(), rreg(), rreg(), rreg(), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 9) != 0));
      adv();
    end

    if (Stats) begin
      for (int n = 0; n < 270000 && m_stall < 65535; n++) begin
        drive_chk(1, 1, 1, 2, 2, 0, 0, 0, 0, 1);
        adv();
      end
      for (int n = 0; n < 4; n++) begin
        drive_chk(1, 1, 1, 2, 2, 0, 0, 0, 0, 1);
        adv();
      end
      drive_chk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
